// File: rtl/gate_truth_table_checker.sv
// Stimulus/response checker for a 2-input combinational gate.
// Each run sweeps {stim_a_o,stim_b_o} through 00,01,10,11, ITERATIONS times. Every vector is
// held SETTLE_CYCLES+1 cycles. dut_out_i is compared with EXP_TT[{a,b}] on the last edge of
// that hold.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_ni           synchronous active-low reset
//   start_i          level; accepted only while idle
//   abort_i          ends a busy run at the next edge, with no done pulse
//   stim_a_o/b_o     registered stimulus to the gate under test
//   dut_out_i        gate response
//   busy_o           run in progress
//   done_o           one-cycle pulse when a run completes
//   pass_o           last completed run had no mismatches
//   mismatch_mask_o  sticky per-vector failure flags; bit index = {a,b}
//   fail_count_o     mismatching samples in the run, saturating at 255
module gate_truth_table_checker #(
    parameter logic [3:0]  EXP_TT        = 4'b0001,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ITERATIONS    = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       stim_a_o,
    output logic       stim_b_o,
    input  logic       dut_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] mismatch_mask_o,
    output logic [7:0] fail_count_o
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StSettle,
        StSample,
        StFinish
    } state_e;

    localparam logic [7:0]  SettleLast = 8'(SETTLE_CYCLES);
    localparam logic [15:0] SweepLast  = 16'(ITERATIONS - 1);
    // With no settle time the single hold cycle is already the sampling cycle.
    localparam state_e      EntryState = (SETTLE_CYCLES == 0) ? StSample : StApply;

    state_e      state_q;
    logic        stim_a_q, stim_b_q;
    logic        busy_q, done_q, pass_q;
    logic [3:0]  mask_q;
    logic [7:0]  fail_q;
    logic [1:0]  vec_q;
    logic [7:0]  settle_q;
    logic [15:0] sweep_q;

    logic        sample_miss;
    logic [3:0]  mask_d;
    logic [7:0]  fail_d;
    logic [7:0]  settle_d;
    logic        last_vec;
    logic [1:0]  vec_d;

    always_comb begin
        sample_miss = 1'b0;
        mask_d      = mask_q;
        fail_d      = fail_q;
        settle_d    = settle_q + 8'd1;
        last_vec    = (vec_q == 2'd3) && (sweep_q == SweepLast);
        vec_d       = vec_q + 2'd1;
        sample_miss = (dut_out_i != EXP_TT[{stim_a_q, stim_b_q}]);
        if (sample_miss) begin
            mask_d = mask_q | (4'b0001 << vec_q);
            if (fail_q != 8'hFF) begin
                fail_d = fail_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            stim_a_q <= 1'b0;
            stim_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mask_q   <= 4'b0000;
            fail_q   <= 8'd0;
            vec_q    <= 2'd0;
            settle_q <= 8'd0;
            sweep_q  <= 16'd0;
        end else if (abort_i && busy_q) begin
            // Any sample due on this edge is dropped; partial mask/count remain visible.
            state_q  <= StIdle;
            stim_a_q <= 1'b0;
            stim_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            vec_q    <= 2'd0;
            settle_q <= 8'd0;
            sweep_q  <= 16'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start_i && !abort_i) begin
                        state_q  <= EntryState;
                        stim_a_q <= 1'b0;
                        stim_b_q <= 1'b0;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        mask_q   <= 4'b0000;
                        fail_q   <= 8'd0;
                        vec_q    <= 2'd0;
                        settle_q <= 8'd0;
                        sweep_q  <= 16'd0;
                    end
                end
                StApply, StSettle: begin
                    settle_q <= settle_d;
                    state_q  <= (settle_d == SettleLast) ? StSample : StSettle;
                end
                StSample: begin
                    mask_q   <= mask_d;
                    fail_q   <= fail_d;
                    settle_q <= 8'd0;
                    if (last_vec) begin
                        state_q  <= StFinish;
                        stim_a_q <= 1'b0;
                        stim_b_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= (fail_d == 8'd0);
                        vec_q    <= 2'd0;
                        sweep_q  <= 16'd0;
                    end else begin
                        state_q  <= EntryState;
                        vec_q    <= vec_d;
                        stim_a_q <= vec_d[1];
                        stim_b_q <= vec_d[0];
                        if (vec_q == 2'd3) begin
                            sweep_q <= sweep_q + 16'd1;
                        end
                    end
                end
                StFinish: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stim_a_o        = stim_a_q;
    assign stim_b_o        = stim_b_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign mismatch_mask_o = mask_q;
    assign fail_count_o    = fail_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench for gate_truth_table_checker. It instantiates three checkers: defaults,
// ITERATIONS=2, and ITERATIONS=100 with SETTLE_CYCLES=0. The gate model can act as a NOR or
// be held stuck at 0 or at 1.
// Latencies are counted in edges after the start-accept edge. done is registered
// 4*ITERATIONS*(SETTLE_CYCLES+1) edges after the accept edge. That makes it visible one cycle
// later, counting from the accept cycle.
module tb_gate_truth_table_checker;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;  // 0: NOR, 1: stuck 0, 2: stuck 1

    logic       start_s [3];
    logic       abort_s [3];
    logic       stim_a_s[3];
    logic       stim_b_s[3];
    logic       dut_out_s[3];
    logic       busy_s  [3];
    logic       done_s  [3];
    logic       pass_s  [3];
    logic [3:0] mask_s  [3];
    logic [7:0] fc_s    [3];

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic gate_model(input logic [1:0] m, input logic a, input logic b);
        case (m)
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~(a | b);
        endcase
    endfunction

    assign dut_out_s[0] = gate_model(mode, stim_a_s[0], stim_b_s[0]);
    assign dut_out_s[1] = gate_model(mode, stim_a_s[1], stim_b_s[1]);
    assign dut_out_s[2] = gate_model(mode, stim_a_s[2], stim_b_s[2]);

    gate_truth_table_checker u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]), .abort_i(abort_s[0]),
        .stim_a_o(stim_a_s[0]), .stim_b_o(stim_b_s[0]), .dut_out_i(dut_out_s[0]),
        .busy_o(busy_s[0]), .done_o(done_s[0]), .pass_o(pass_s[0]),
        .mismatch_mask_o(mask_s[0]), .fail_count_o(fc_s[0])
    );

    gate_truth_table_checker #(.ITERATIONS(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]), .abort_i(abort_s[1]),
        .stim_a_o(stim_a_s[1]), .stim_b_o(stim_b_s[1]), .dut_out_i(dut_out_s[1]),
        .busy_o(busy_s[1]), .done_o(done_s[1]), .pass_o(pass_s[1]),
        .mismatch_mask_o(mask_s[1]), .fail_count_o(fc_s[1])
    );

    gate_truth_table_checker #(.ITERATIONS(100), .SETTLE_CYCLES(0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[2]), .abort_i(abort_s[2]),
        .stim_a_o(stim_a_s[2]), .stim_b_o(stim_b_s[2]), .dut_out_i(dut_out_s[2]),
        .busy_o(busy_s[2]), .done_o(done_s[2]), .pass_o(pass_s[2]),
        .mismatch_mask_o(mask_s[2]), .fail_count_o(fc_s[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_run(input int d);
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
    endtask

    // Ticks until done is seen or the budget runs out. A timeout returns budget+1, which the
    // caller's latency check rejects.
    task automatic run_to_done(input int d, input int budget, output int lat);
        lat = 0;
        while (done_s[d] !== 1'b1 && lat <= budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic chk_idle_zero(input string tag, input int d);
        chk({tag, "_busy"}, 32'(busy_s[d]), 32'd0);
        chk({tag, "_done"}, 32'(done_s[d]), 32'd0);
        chk({tag, "_pass"}, 32'(pass_s[d]), 32'd0);
        chk({tag, "_mask"}, 32'(mask_s[d]), 32'd0);
        chk({tag, "_fc"}, 32'(fc_s[d]), 32'd0);
        chk({tag, "_stim"}, 32'({stim_a_s[d], stim_b_s[d]}), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        mode  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            abort_s[i] = 1'b0;
        end
        tick();
        tick();
        chk_idle_zero("rst", 0);
        chk_idle_zero("rst1", 1);
        rst_n = 1'b1;
        tick();
        tick();

        // Correct NOR: each vector is held 3 cycles, and done comes 12 edges after accept.
        start_run(0);
        chk("nor_busy0", 32'(busy_s[0]), 32'd1);
        chk("nor_stim0", 32'({stim_a_s[0], stim_b_s[0]}), 32'd0);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk($sformatf("nor_stim%0d", k), 32'({stim_a_s[0], stim_b_s[0]}), 32'(k / 3));
            chk($sformatf("nor_busy%0d", k), 32'(busy_s[0]), 32'd1);
        end
        tick();
        chk("nor_done", 32'(done_s[0]), 32'd1);
        chk("nor_busy_end", 32'(busy_s[0]), 32'd0);
        chk("nor_pass", 32'(pass_s[0]), 32'd1);
        chk("nor_mask", 32'(mask_s[0]), 32'd0);
        chk("nor_fc", 32'(fc_s[0]), 32'd0);
        chk("nor_stim_end", 32'({stim_a_s[0], stim_b_s[0]}), 32'd0);
        tick();
        chk("nor_done_pulse", 32'(done_s[0]), 32'd0);
        chk("nor_pass_hold", 32'(pass_s[0]), 32'd1);
        tick();

        // Stuck at 0: only vector 00, which expects 1, fails.
        mode = 2'd1;
        start_run(0);
        chk("s0_pass_clr", 32'(pass_s[0]), 32'd0);
        run_to_done(0, 50, lat);
        chk("s0_lat", 32'(lat), 32'd12);
        chk("s0_pass", 32'(pass_s[0]), 32'd0);
        chk("s0_mask", 32'(mask_s[0]), 32'h1);
        chk("s0_fc", 32'(fc_s[0]), 32'd1);
        tick();

        // Stuck at 1 with two sweeps: 01, 10 and 11 fail twice each.
        mode = 2'd2;
        start_run(1);
        run_to_done(1, 60, lat);
        chk("s1x2_lat", 32'(lat), 32'd24);
        chk("s1x2_pass", 32'(pass_s[1]), 32'd0);
        chk("s1x2_mask", 32'(mask_s[1]), 32'hE);
        chk("s1x2_fc", 32'(fc_s[1]), 32'd6);
        tick();

        // Stuck at 1 with 100 sweeps and no settle time: 300 failures saturate at 255.
        start_run(2);
        run_to_done(2, 500, lat);
        chk("s1x100_lat", 32'(lat), 32'd400);
        chk("s1x100_fc", 32'(fc_s[2]), 32'd255);
        chk("s1x100_mask", 32'(mask_s[2]), 32'hE);
        chk("s1x100_pass", 32'(pass_s[2]), 32'd0);
        tick();

        // A second start while busy is ignored. Abort at vector 10 then returns to idle.
        mode = 2'd0;
        start_run(0);
        tick();
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("ab_stim10", 32'({stim_a_s[0], stim_b_s[0]}), 32'd2);
        chk("ab_busy_pre", 32'(busy_s[0]), 32'd1);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        chk("ab_busy", 32'(busy_s[0]), 32'd0);
        chk("ab_done", 32'(done_s[0]), 32'd0);
        chk("ab_stim", 32'({stim_a_s[0], stim_b_s[0]}), 32'd0);
        chk("ab_pass", 32'(pass_s[0]), 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) seen++;
        end
        chk("ab_quiet", 32'(seen), 32'd0);

        // Reset during the settle phase of vector 01, after a stuck-0 miss on 00.
        mode = 2'd1;
        start_run(0);
        for (int k = 0; k < 3; k++) tick();
        chk("rs_mask_pre", 32'(mask_s[0]), 32'h1);
        chk("rs_fc_pre", 32'(fc_s[0]), 32'd1);
        chk("rs_stim_pre", 32'({stim_a_s[0], stim_b_s[0]}), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle_zero("rs", 0);
        mode = 2'd0;
        start_run(0);
        run_to_done(0, 50, lat);
        chk("rs_lat", 32'(lat), 32'd12);
        chk("rs_pass", 32'(pass_s[0]), 32'd1);
        chk("rs_mask", 32'(mask_s[0]), 32'd0);
        chk("rs_fc", 32'(fc_s[0]), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
